// File: rtl/acc_feed_6.sv
// rtl/acc_feed_6.sv - packs 32-bit stream words into 6-lane vectors for the FP32 accumulator bank
// Optional feature macro: ACC_FEED_ZERO_PAD_EN (s_tlast closes a short, zero-padded vector)
module acc_feed_6 #(
  parameter int LANES = 6,
  parameter int DW    = 32,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_start,
  input  logic [CNT_W-1:0]    cfg_len,
  input  logic [CNT_W-1:0]    cfg_groups,
  input  logic [DW-1:0]       s_tdata,
  input  logic                s_tvalid,
  input  logic                s_tlast,
  output logic                s_tready,
  output logic [LANES*DW-1:0] V192,
  output logic                last,
  output logic                v_valid,
  output logic                busy,
  output logic                done
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t              state;
  logic [2:0]          lane_idx;
  logic [LANES*DW-1:0] pack;
  logic [LANES*DW-1:0] nxt_vec;
  logic [CNT_W-1:0]    len_r, grp_r, vec_cnt, grp_cnt;
  logic                hs, emit, force_last, is_last, is_end;

  assign hs = s_tvalid & s_tready;

`ifdef ACC_FEED_ZERO_PAD_EN
  assign emit       = hs & ((lane_idx == 3'(LANES-1)) | s_tlast);
  assign force_last = s_tlast;
`else
  logic unused_tlast;
  assign unused_tlast = s_tlast;
  assign emit         = hs & (lane_idx == 3'(LANES-1));
  assign force_last   = 1'b0;
`endif

  assign is_last = force_last | (vec_cnt == len_r - CNT_W'(1));
  assign is_end  = is_last & (grp_cnt == grp_r - CNT_W'(1));

  // Lanes below the current one come from the pack register, the current lane
  // bypasses straight from s_tdata, and anything above it is +0.0 padding.
  always_comb begin
    nxt_vec = '0;
    for (int k = 0; k < LANES; k++) begin
      if (3'(k) < lane_idx)
        nxt_vec[k*DW +: DW] = pack[k*DW +: DW];
      else if (3'(k) == lane_idx)
        nxt_vec[k*DW +: DW] = s_tdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      lane_idx <= '0;
      pack     <= '0;
      len_r    <= '0;
      grp_r    <= '0;
      vec_cnt  <= '0;
      grp_cnt  <= '0;
      V192     <= '0;
      last     <= 1'b0;
      v_valid  <= 1'b0;
      s_tready <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      // The accumulator eats a beat every cycle, so non-vector beats are zeros.
      V192    <= '0;
      last    <= 1'b0;
      v_valid <= 1'b0;
      done    <= 1'b0;

      if (hs) begin
        pack[int'(lane_idx)*DW +: DW] <= s_tdata;
        lane_idx <= emit ? 3'd0 : lane_idx + 3'd1;
      end

      if (emit) begin
        V192    <= nxt_vec;
        v_valid <= 1'b1;
        last    <= is_last;
        done    <= is_end;
        if (is_last) begin
          vec_cnt <= '0;
          grp_cnt <= grp_cnt + CNT_W'(1);
        end else begin
          vec_cnt <= vec_cnt + CNT_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (cfg_start) begin
            len_r    <= (cfg_len == '0) ? CNT_W'(1) : cfg_len;
            grp_r    <= (cfg_groups == '0) ? CNT_W'(1) : cfg_groups;
            lane_idx <= '0;
            vec_cnt  <= '0;
            grp_cnt  <= '0;
            s_tready <= 1'b1;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (emit && is_end) begin
            s_tready <= 1'b0;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_acc_feed_6.sv
// tb/tb_acc_feed_6.sv - randomized self-checking bench for acc_feed_6 against a vector-level model
module tb_acc_feed_6;
  localparam int LANES = 6;
  localparam int DW    = 32;
  localparam int CNT_W = 8;
  localparam int VW    = LANES*DW;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_start = 1'b0;
  logic [CNT_W-1:0] cfg_len = '0;
  logic [CNT_W-1:0] cfg_groups = '0;
  logic [DW-1:0]    s_tdata = '0;
  logic             s_tvalid = 1'b0;
  logic             s_tlast = 1'b0;
  logic             s_tready;
  logic [VW-1:0]    V192;
  logic             last, v_valid, busy, done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  acc_feed_6 dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_len(cfg_len),
    .cfg_groups(cfg_groups), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tlast(s_tlast), .s_tready(s_tready), .V192(V192), .last(last),
    .v_valid(v_valid), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Model: vector i of a run holds words 6i..6i+5, closes a group when
  // (i+1) is a multiple of len, and ends the run at i == len*groups-1.
  task automatic run_case(input int len, input int grp, input int gap, input bit seq);
    int eff_l, eff_g, nvec, total, acc, post, cyc, vi;
    bit drv, tr, hs, exp_v;
    logic [DW-1:0] words[$];
    logic [VW-1:0] ev;
    eff_l = (len == 0) ? 1 : len;
    eff_g = (grp == 0) ? 1 : grp;
    nvec  = eff_l * eff_g;
    total = 6 * nvec;
    for (int i = 0; i < total; i++) words.push_back(seq ? DW'(i + 1) : DW'($urandom));
    @(negedge clk);
    cfg_len = CNT_W'(len); cfg_groups = CNT_W'(grp); cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    chk("start_tready", s_tready, 1);
    chk("start_busy", busy, 1);
    acc = 0; post = 0; cyc = 0;
    while (post < 2 && cyc < 4000) begin
      drv = (acc >= total) || ($urandom_range(99) >= gap);
      s_tvalid  = drv;
      s_tdata   = (acc < total) ? words[acc] : 32'hdeadbeef;
      cfg_start = (acc == 7);
      tr = s_tready;
      @(negedge clk);
      cyc++;
      hs = drv && tr;
      if (hs) acc++;
      exp_v = hs && (acc % 6 == 0) && (acc <= total);
      chk("v_valid", v_valid, exp_v);
      if (exp_v) begin
        vi = acc / 6 - 1;
        for (int k = 0; k < 6; k++) ev[k*DW +: DW] = words[vi*6 + k];
        chk("vector", V192, ev);
        chk("last", last, ((vi + 1) % eff_l) == 0);
        chk("done", done, vi == nvec - 1);
      end else begin
        chk("idle_v192", V192, 0);
        chk("idle_last", last, 0);
        chk("idle_done", done, 0);
      end
      chk("s_tready", s_tready, acc < total);
      chk("busy", busy, post == 0);
      if (acc >= total) post++;
    end
    s_tvalid = 1'b0; cfg_start = 1'b0;
    chk("accepted_words", acc, total);
    chk("run_finished", post, 2);
  endtask

  initial begin
    logic [DW-1:0] pw [9];
    logic [VW-1:0] ev;

    repeat (3) @(negedge clk);
    chk("rst_v192", V192, 0);
    chk("rst_tready", s_tready, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("idle_v192", V192, 0);
    chk("idle_last", last, 0);
    chk("idle_vvalid", v_valid, 0);
    chk("idle_tready", s_tready, 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);

    run_case(2, 1, 0, 1'b1);
    run_case(0, 3, 0, 1'b0);
    run_case(3, 2, 50, 1'b0);
    run_case(3, 2, 0, 1'b0);

    // Reset in the middle of a vector, then a fresh one-vector run.
    @(negedge clk);
    cfg_len = 8'd2; cfg_groups = 8'd1; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_tvalid = 1'b1; s_tdata = $urandom;
      @(negedge clk);
    end
    s_tvalid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_v192", V192, 0);
    chk("midrst_vvalid", v_valid, 0);
    chk("midrst_tready", s_tready, 0);
    chk("midrst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    run_case(1, 1, 0, 1'b0);

`ifdef ACC_FEED_ZERO_PAD_EN
    for (int i = 0; i < 9; i++) pw[i] = $urandom;
    @(negedge clk);
    cfg_len = 8'd4; cfg_groups = 8'd2; cfg_start = 1'b1;
    @(negedge clk);
    cfg_start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      s_tvalid = 1'b1; s_tdata = pw[i]; s_tlast = (i == 2);
      @(negedge clk);
      if (i == 2) begin
        ev = '0;
        for (int k = 0; k < 3; k++) ev[k*DW +: DW] = pw[k];
        chk("pad_vvalid", v_valid, 1);
        chk("pad_vector", V192, ev);
        chk("pad_last", last, 1);
        chk("pad_done", done, 0);
      end else if (i == 8) begin
        for (int k = 0; k < 6; k++) ev[k*DW +: DW] = pw[3 + k];
        chk("post_pad_vvalid", v_valid, 1);
        chk("post_pad_vector", V192, ev);
        chk("post_pad_last", last, 0);
      end else begin
        chk("pad_idle_vvalid", v_valid, 0);
      end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
`else
    pw[0] = '0;
    ev = '0;
    chk("final_idle_tready", s_tready, {ev[VW-1:DW], pw[0]});
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
